// File: rtl/reg1_pair_tx.sv
// reg1_pair_tx: word-to-pair serializer feeding the reg1 capture block.
// Words enter via valid/ready into a DEPTH-word FIFO and leave as a
// gapless stream of 2-bit symbols, least-significant pair first.
// Optional feature macro: PAIR_TX_PARITY_EN adds a trailing parity
// symbol {1'b1, ^word} after each word's data symbols.
module reg1_pair_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic [1:0]       pair,
    output logic             pair_vld,
    output logic             sof,
    output logic             busy,
    output logic [15:0]      frames
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NSYM = WIDTH / 2;
    // Keep the index at least one bit wide so WIDTH=2 still elaborates
    localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSYM - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef PAIR_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [IW-1:0]    idx_reg;
    state_t           state_reg;
`ifdef PAIR_TX_PARITY_EN
    logic             par_reg;
`endif

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    assign s_ready = (count_reg != FULL_CNT);
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr_reg];
    assign busy    = (state_reg != IDLE) || (count_reg != '0);

    // Pop decision: a new word is loaded whenever the serializer finishes
    // (or is idle) and the FIFO holds something, so words run back-to-back
    always_comb begin
        pop = 1'b0;
        if (count_reg != '0) begin
            case (state_reg)
                IDLE:   pop = 1'b1;
`ifdef PAIR_TX_PARITY_EN
                SHIFT:  pop = 1'b0;
                PARITY: pop = 1'b1;
`else
                SHIFT:  pop = (idx_reg == LAST_IDX);
`endif
                default: pop = 1'b0;
            endcase
        end
    end

    // FIFO storage write; storage itself needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= s_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Serializer FSM with registered symbol outputs and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            idx_reg   <= '0;
            pair      <= 2'b00;
            pair_vld  <= 1'b0;
            sof       <= 1'b0;
            frames    <= 16'd0;
`ifdef PAIR_TX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            pair     <= 2'b00;
            pair_vld <= 1'b0;
            sof      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        shreg_reg <= head;
                        idx_reg   <= '0;
`ifdef PAIR_TX_PARITY_EN
                        par_reg   <= ^head;
`endif
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    pair      <= shreg_reg[1:0];
                    pair_vld  <= 1'b1;
                    sof       <= (idx_reg == '0);
                    shreg_reg <= shreg_reg >> 2;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
`ifdef PAIR_TX_PARITY_EN
                        state_reg <= PARITY;
`else
                        frames <= frames + 16'd1;
                        if (pop) begin
                            shreg_reg <= head;
                            idx_reg   <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
`endif
                    end
                end
`ifdef PAIR_TX_PARITY_EN
                PARITY: begin
                    pair     <= {1'b1, par_reg};
                    pair_vld <= 1'b1;
                    frames   <= frames + 16'd1;
                    if (pop) begin
                        shreg_reg <= head;
                        idx_reg   <= '0;
                        par_reg   <= ^head;
                        state_reg <= SHIFT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg1_pair_tx.sv
// Scoreboard bench for reg1_pair_tx: directed words push expected
// symbols into a queue, monitors pop and compare on every valid symbol.
// A second WIDTH=2 instance streams 65536 words to exercise frame wrap.
module tb_reg1_pair_tx;

`ifdef PAIR_TX_PARITY_EN
    localparam int SYMS = 5;
    localparam int SYMS2 = 2;
`else
    localparam int SYMS = 4;
    localparam int SYMS2 = 1;
`endif

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [1:0]  pair;
    logic        pair_vld;
    logic        sof;
    logic        busy;
    logic [15:0] frames;

    logic        rst2;
    logic        s_valid2;
    logic        s_ready2;
    logic [1:0]  s_data2;
    logic [1:0]  pair2;
    logic        pair_vld2;
    logic        sof2;
    logic        busy2;
    logic [15:0] frames2;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] q[$];
    logic [2:0] q2[$];
    int run = 0;
    int maxrun = 0;
    bit w2_done = 0;
    bit saw_ffff = 0;
    bit saw_wrap = 0;
    logic [15:0] prev2 = 16'd0;
    int pushed2 = 0;

    reg1_pair_tx #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .pair(pair), .pair_vld(pair_vld), .sof(sof),
        .busy(busy), .frames(frames)
    );

    reg1_pair_tx #(.WIDTH(2), .DEPTH(2)) u_w2 (
        .clk(clk), .rst(rst2), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_data(s_data2), .pair(pair2), .pair_vld(pair_vld2), .sof(sof2),
        .busy(busy2), .frames(frames2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [7:0] d);
        for (int i = 0; i < 4; i++) begin
            q.push_back({(i == 0), d[2*i +: 2]});
        end
`ifdef PAIR_TX_PARITY_EN
        q.push_back({1'b0, 1'b1, ^d});
`endif
    endtask

    task automatic push_word(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("push_ready_timeout", {31'd0, t < 100}, 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        expect_word(d);
        @(posedge clk);
        #1 s_valid = 1'b0;
        $display("push data=%02h", d);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || pair_vld) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", {31'd0, t < 200}, 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        maxrun = 0;
        run = 0;
    endtask

    // Main scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (pair_vld) begin
                run++;
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_symbol: got pair=%b sof=%b required none", pair, sof);
                end else begin
                    logic [2:0] e;
                    e = q.pop_front();
                    if ({sof, pair} !== e) begin
                        n_err++;
                        $display("FAIL symbol: got sof=%b pair=%b required sof=%b pair=%b", sof, pair, e[2], e[1:0]);
                    end else begin
                        $display("sym pair=%b sof=%b frames=%0d", pair, sof, frames);
                    end
                end
            end else begin
                if (run > maxrun) maxrun = run;
                run = 0;
                check("idle_outputs_zero", {29'd0, sof, pair}, 32'd0);
            end
        end
    end

    // WIDTH=2 monitor: symbol stream and frame counter progression
    always @(negedge clk) begin
        if (!rst2) begin
            if (pair_vld2) begin
                n_vec++;
                if (q2.size() == 0) begin
                    n_err++;
                    $display("FAIL w2_unexpected: got pair=%b required none", pair2);
                end else begin
                    logic [2:0] e;
                    e = q2.pop_front();
                    if ({sof2, pair2} !== e) begin
                        n_err++;
                        $display("FAIL w2_symbol: got sof=%b pair=%b required sof=%b pair=%b", sof2, pair2, e[2], e[1:0]);
                    end
                end
            end
            if (frames2 != prev2 && frames2 != prev2 + 16'd1) begin
                n_err++;
                $display("FAIL w2_frames_step: got %0h previous %0h", frames2, prev2);
            end
            if (frames2 == 16'hFFFF) saw_ffff = 1'b1;
            if (prev2 == 16'hFFFF && frames2 == 16'h0000) begin
                saw_wrap = 1'b1;
                $display("w2 frames wrap ffff->0000");
            end
            prev2 = frames2;
        end
    end

    // WIDTH=2 stream of 65536 words
    initial begin
        int t;
        logic [1:0] d;
        rst2 = 1'b1;
        s_valid2 = 1'b0;
        s_data2 = 2'b00;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        while (pushed2 < 65536) begin
            @(negedge clk);
            if (s_ready2) begin
                d = 2'(pushed2) ^ 2'(pushed2 >> 8);
                s_valid2 = 1'b1;
                s_data2 = d;
                q2.push_back({1'b1, d});
`ifdef PAIR_TX_PARITY_EN
                q2.push_back({1'b0, 1'b1, ^d});
`endif
                pushed2++;
            end else begin
                s_valid2 = 1'b0;
            end
        end
        @(negedge clk);
        s_valid2 = 1'b0;
        t = 0;
        while ((q2.size() != 0 || busy2) && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("w2_drain_timeout", {31'd0, t < 100}, 32'd1);
        check("w2_frames_final", {16'd0, frames2}, 32'd0);
        check("w2_saw_ffff", {31'd0, saw_ffff}, 32'd1);
        check("w2_saw_wrap", {31'd0, saw_wrap}, 32'd1);
        $display("w2 stream done words=%0d symbols_per_word=%0d", pushed2, SYMS2);
        w2_done = 1'b1;
    end

    // Directed main sequence
    initial begin
        int t;
        int nxt;
        bit saw_full;
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        #1 rst = 1'b1;
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_pair", {30'd0, pair}, 32'd0);
        check("rst_pair_vld", {31'd0, pair_vld}, 32'd0);
        check("rst_sof", {31'd0, sof}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frames", {16'd0, frames}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word 0xB4 with latency check
        push_word(8'hB4);
        @(negedge clk);
        check("lat_n1_vld", {31'd0, pair_vld}, 32'd0);
        @(negedge clk);
        check("lat_n2_vld", {31'd0, pair_vld}, 32'd0);
        @(negedge clk);
        check("lat_first_vld", {31'd0, pair_vld}, 32'd1);
        check("lat_first_sof", {31'd0, sof}, 32'd1);
        wait_idle();
        check("single_frames", {16'd0, frames}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd0);
        check("single_run", maxrun, SYMS);

        // Backpressure: 0x00..0x07 with s_valid held high
        do_reset();
        nxt = 0;
        t = 0;
        saw_full = 0;
        while (nxt < 8 && t < 300) begin
            @(negedge clk);
            t++;
            s_valid = 1'b1;
            s_data = 8'(nxt);
            if (s_ready) begin
                expect_word(8'(nxt));
                $display("push data=%02h", nxt);
                nxt++;
            end else if (!saw_full) begin
                saw_full = 1;
                check("bp_full_after", nxt, 5);
            end
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        check("bp_timeout", {31'd0, t < 300}, 32'd1);
        wait_idle();
        check("bp_saw_full", {31'd0, saw_full}, 32'd1);
        check("bp_frames", {16'd0, frames}, 32'd8);
        check("bp_run", maxrun, 8 * SYMS);

        // Push/pop collision keeping occupancy at 2
        do_reset();
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? SYMS - 2 : SYMS - 1) @(posedge clk);
            push_word(8'h40 + 8'(k));
            check("coll_ready", {31'd0, s_ready}, 32'd1);
            check("coll_busy", {31'd0, busy}, 32'd1);
        end
        wait_idle();
        check("coll_frames", {16'd0, frames}, 32'd7);
        check("coll_run", maxrun, 7 * SYMS);

        // Reset during symbol index 2 of 0xFF
        push_word(8'hFF);
        repeat (4) @(posedge clk);
        #2;
        check("mid_vld_before", {31'd0, pair_vld}, 32'd1);
        check("mid_pair_before", {30'd0, pair}, 32'd3);
        rst = 1'b1;
        q.delete();
        #1;
        check("mid_async_vld", {31'd0, pair_vld}, 32'd0);
        check("mid_async_frames", {16'd0, frames}, 32'd0);
        check("mid_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 0;
        maxrun = 0;
        push_word(8'h01);
        wait_idle();
        check("mid_frames_after", {16'd0, frames}, 32'd1);

        t = 0;
        while (!w2_done && t < 80000) begin
            @(negedge clk);
            t++;
        end
        check("w2_done_timeout", {31'd0, w2_done}, 32'd1);
        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
